// File: rtl/mac_lane_acc.sv
// -----------------------------------------------------------------------------
// mac_lane_acc
//   Multi-lane multiply-accumulate engine. Each of `col` lanes multiplies an
//   unsigned activation by a signed weight and accumulates into a signed
//   partial sum seeded from `c` on the first beat of a dot product. The dot
//   product length is taken from `len` on the first beat (0 counts as 1).
//   Results are presented in HOLD with a ready/valid handshake; a new first
//   beat may be accepted in the same cycle the result is consumed.
//
//   Optional feature macro: MAC_LANE_SAT_EN
//     defined   -> each accumulate step saturates to the signed psum range
//     undefined -> each accumulate step wraps modulo 2^psum_bw
//     `ovf` flags an out-of-range step in both builds.
//
//   Ports
//     clk        in   clock, rising edge
//     reset      in   asynchronous active-high reset
//     len        in   beats per dot product (first beat only)
//     in_valid   in   input beat valid
//     in_ready   out  input beat accepted when in_valid & in_ready
//     a          in   col x bw unsigned activations, lane i = a[i*bw +: bw]
//     b          in   col x bw signed weights,      lane i = b[i*bw +: bw]
//     c          in   col x psum_bw signed seeds (first beat only)
//     out_valid  out  result valid
//     out_ready  in   result consumed when out_valid & out_ready
//     out        out  col x psum_bw signed lane results (registered)
//     ovf        out  per-lane sticky overflow of the current dot product
// -----------------------------------------------------------------------------

// One lane: datapath plus its accumulator and sticky overflow flops.
//   clk, reset   clock / async reset
//   en           accepted beat this cycle
//   first        accepted beat is the first of a dot product (seed from c)
//   a, b, c      lane activation, weight, seed
//   acc, ovf     registered partial sum and sticky overflow
module mac_lane_unit #(
   parameter int bw      = 4,
   parameter int psum_bw = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               first,
   input  logic [bw-1:0]      a,
   input  logic [bw-1:0]      b,
   input  logic [psum_bw-1:0] c,
   output logic [psum_bw-1:0] acc,
   output logic               ovf
);
   logic [psum_bw-1:0] acc_q, acc_d;
   logic               ovf_q, ovf_d;

   logic [2*bw:0]      a_x, b_x, prod;
   logic [psum_bw:0]   prod_x, base_x, sum;
   logic [psum_bw-1:0] base, result;
   logic               beat_ovf;

   always_comb begin
      // Operands extended to the full product width so the low 2*bw+1 bits
      // of an ordinary multiply are the exact signed product.
      a_x    = {{(bw+1){1'b0}}, a};
      b_x    = {{(bw+1){b[bw-1]}}, b};
      prod   = a_x * b_x;
      prod_x = {{(psum_bw-2*bw){prod[2*bw]}}, prod};

      base   = first ? c : acc_q;
      base_x = {base[psum_bw-1], base};
      sum    = base_x + prod_x;

      // Out of range when the guard bit disagrees with the psum sign bit.
      beat_ovf = sum[psum_bw] ^ sum[psum_bw-1];

`ifdef MAC_LANE_SAT_EN
      if (beat_ovf)
         result = sum[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                               : {1'b0, {(psum_bw-1){1'b1}}};
      else
         result = sum[psum_bw-1:0];
`else
      result = sum[psum_bw-1:0];
`endif

      acc_d = acc_q;
      ovf_d = ovf_q;
      if (en) begin
         acc_d = result;
         ovf_d = first ? beat_ovf : (ovf_q | beat_ovf);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         ovf_q <= ovf_d;
      end
   end

   assign acc = acc_q;
   assign ovf = ovf_q;
endmodule

module mac_lane_acc #(
   parameter int bw      = 4,
   parameter int psum_bw = 16,
   parameter int col     = 8,
   parameter int cnt_bw  = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [cnt_bw-1:0]      len,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [col*bw-1:0]      a,
   input  logic [col*bw-1:0]      b,
   input  logic [col*psum_bw-1:0] c,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [col*psum_bw-1:0] out,
   output logic [col-1:0]         ovf
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [cnt_bw-1:0] cnt_q, cnt_d;
   logic [cnt_bw-1:0] len_q, len_d;
   logic [cnt_bw-1:0] len_eff, cnt_inc;
   logic              accept, first;

   logic [col-1:0][bw-1:0]      a_l, b_l;
   logic [col-1:0][psum_bw-1:0] c_l, acc_l;

   assign a_l = a;
   assign b_l = b;
   assign c_l = c;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      first     = 1'b0;
      len_eff   = (len == '0) ? cnt_bw'(1) : len;
      cnt_inc   = cnt_q + cnt_bw'(1);

      case (state_q)
         IDLE: in_ready = 1'b1;
         ACC:  in_ready = 1'b1;
         HOLD: begin
            out_valid = 1'b1;
            // A new first beat may only enter while the result leaves.
            in_ready  = out_ready;
         end
         default: ;
      endcase
      if (reset) in_ready = 1'b0;

      accept = in_valid & in_ready;

      case (state_q)
         IDLE: if (accept) first = 1'b1;
         ACC: begin
            if (accept) begin
               cnt_d = cnt_inc;
               if (cnt_inc == len_q) state_d = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
               if (accept) first = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // First-beat rules are shared by IDLE and the HOLD back-to-back case.
      if (first) begin
         cnt_d   = cnt_bw'(1);
         len_d   = len_eff;
         state_d = (len_eff == cnt_bw'(1)) ? HOLD : ACC;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
      end
   end

   for (genvar i = 0; i < col; i++) begin : g_lane
      mac_lane_unit #(
         .bw      (bw),
         .psum_bw (psum_bw)
      ) u_lane (
         .clk   (clk),
         .reset (reset),
         .en    (accept),
         .first (first),
         .a     (a_l[i]),
         .b     (b_l[i]),
         .c     (c_l[i]),
         .acc   (acc_l[i]),
         .ovf   (ovf[i])
      );
   end

   // The accumulator only moves on an accepted beat, and in HOLD a beat is
   // accepted only as the result is consumed, so it doubles as the
   // registered output.
   assign out = acc_l;
endmodule

// File: tb/tb_mac_lane_acc.sv
// Directed/random bench for mac_lane_acc with an integer reference model of
// the lane arithmetic (c + sum of a*b, wrapped or clamped per step).
module tb_mac_lane_acc;
   localparam int BW   = 4;
   localparam int PBW  = 16;
   localparam int COL  = 8;
   localparam int CBW  = 8;
   localparam int PMAX = 2**(PBW-1) - 1;
   localparam int PMIN = -(2**(PBW-1));

   logic                 clk = 1'b0;
   logic                 reset;
   logic [CBW-1:0]       len;
   logic                 in_valid;
   logic                 in_ready;
   logic [COL*BW-1:0]    a, b;
   logic [COL*PBW-1:0]   c;
   logic                 out_valid;
   logic                 out_ready;
   logic [COL*PBW-1:0]   out;
   logic [COL-1:0]       ovf;

   mac_lane_acc #(.bw(BW), .psum_bw(PBW), .col(COL), .cnt_bw(CBW)) dut (
      .clk(clk), .reset(reset), .len(len), .in_valid(in_valid),
      .in_ready(in_ready), .a(a), .b(b), .c(c), .out_valid(out_valid),
      .out_ready(out_ready), .out(out), .ovf(ovf)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [COL*BW-1:0]  a_v, b_v;
   logic [COL*PBW-1:0] c_v;
   int                 m_acc [COL];
   bit                 m_ovf [COL];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [COL*PBW-1:0] exp_out();
      logic [COL*PBW-1:0] o;
      for (int i = 0; i < COL; i++) o[i*PBW +: PBW] = PBW'(m_acc[i]);
      return o;
   endfunction

   function automatic logic [COL-1:0] exp_ovf();
      logic [COL-1:0] o;
      for (int i = 0; i < COL; i++) o[i] = m_ovf[i];
      return o;
   endfunction

   // One accepted beat applied to the model, lane by lane.
   task automatic model_beat(input bit first);
      for (int i = 0; i < COL; i++) begin
         int av, bv, cv, base, res;
         bit o;
         av   = int'(a_v[i*BW +: BW]);
         bv   = int'($signed(b_v[i*BW +: BW]));
         cv   = int'($signed(c_v[i*PBW +: PBW]));
         base = first ? cv : m_acc[i];
         res  = base + av * bv;
         o    = (res > PMAX) || (res < PMIN);
`ifdef MAC_LANE_SAT_EN
         if (res > PMAX) res = PMAX;
         else if (res < PMIN) res = PMIN;
`else
         if (res > PMAX) res = res - 2**PBW;
         else if (res < PMIN) res = res + 2**PBW;
`endif
         m_acc[i] = res;
         m_ovf[i] = first ? o : (m_ovf[i] | o);
      end
   endtask

   task automatic rnd_data();
      a_v = $urandom;
      b_v = $urandom;
      c_v = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // Called just after a negedge with the DUT able to accept.
   task automatic beat(input bit first, input logic [CBW-1:0] l);
      a = a_v; b = b_v; c = c_v; len = l; in_valid = 1'b1;
      #1 chk("in_ready", 128'(in_ready), 128'(1));
      model_beat(first);
      @(negedge clk);
      in_valid = 1'b0;
      len = CBW'($urandom);
      a = $urandom; b = $urandom;
   endtask

   task automatic check_out(input string tag);
      chk({tag, " valid"}, 128'(out_valid), 128'(1));
      chk({tag, " out"}, 128'(out), 128'(exp_out()));
      chk({tag, " ovf"}, 128'(ovf), 128'(exp_ovf()));
   endtask

   task automatic consume(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, " drained"}, 128'(out_valid), 128'(0));
   endtask

   task automatic run_dp(input int l_drive, input int nbeats, input bit gaps, input string tag);
      for (int k = 0; k < nbeats; k++) begin
         rnd_data();
         beat(k == 0, CBW'(l_drive));
         if (k < nbeats - 1) begin
            chk({tag, " early"}, 128'(out_valid), 128'(0));
            if (gaps) begin
               repeat ($urandom_range(0, 2)) begin
                  @(negedge clk);
                  chk({tag, " gap"}, 128'(out_valid), 128'(0));
               end
            end
         end
      end
      check_out(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      logic [COL*PBW-1:0] held;
      reset = 1'b1; len = '0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; c = '0;
      @(negedge clk);
      chk("rst in_ready", 128'(in_ready), 128'(0));
      chk("rst out_valid", 128'(out_valid), 128'(0));
      chk("rst out", 128'(out), 128'(0));
      chk("rst ovf", 128'(ovf), 128'(0));
      reset = 1'b0;
      #1 chk("idle in_ready", 128'(in_ready), 128'(1));
      @(negedge clk);

      // Single beat, lane0 15 * -8.
      a_v = '0; b_v = '0; c_v = '0;
      a_v[3:0] = 4'd15; b_v[3:0] = 4'h8;
      beat(1'b1, CBW'(1));
      check_out("len1");
      chk("len1 lane0", 128'(out[15:0]), 128'(16'hFF88));
      consume("len1");

      // Length 10 with random gaps and junk len on later beats.
      run_dp(10, 10, 1'b1, "len10");
      consume("len10");

      // Stall in HOLD, then back-to-back first beat.
      run_dp(2, 2, 1'b0, "stall_pre");
      held = out;
      rnd_data();
      a = a_v; b = b_v; c = c_v; len = CBW'(1); in_valid = 1'b1;
      #1 chk("stall in_ready", 128'(in_ready), 128'(0));
      repeat (5) begin
         @(negedge clk);
         chk("stall valid", 128'(out_valid), 128'(1));
         chk("stall out", 128'(out), 128'(held));
         chk("stall in_ready", 128'(in_ready), 128'(0));
      end
      out_ready = 1'b1;
      #1 chk("b2b in_ready", 128'(in_ready), 128'(1));
      model_beat(1'b1);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      check_out("nobubble");
      consume("nobubble");

      // Overflow corner on lane0.
      a_v = '0; b_v = '0; c_v = '0;
      a_v[3:0] = 4'd15; b_v[3:0] = 4'd7; c_v[15:0] = 16'd32760;
      beat(1'b1, CBW'(1));
      check_out("ovf");
`ifdef MAC_LANE_SAT_EN
      chk("ovf lane0", 128'(out[15:0]), 128'(16'h7FFF));
`else
      chk("ovf lane0", 128'(out[15:0]), 128'(16'h8061));
`endif
      chk("ovf flag0", 128'(ovf[0]), 128'(1));
      consume("ovf");

      // Reset after 3 of 5 beats.
      for (int k = 0; k < 3; k++) begin
         rnd_data();
         beat(k == 0, CBW'(5));
      end
      reset = 1'b1;
      #1;
      chk("midrst valid", 128'(out_valid), 128'(0));
      chk("midrst ovf", 128'(ovf), 128'(0));
      chk("midrst out", 128'(out), 128'(0));
      chk("midrst in_ready", 128'(in_ready), 128'(0));
      @(negedge clk);
      reset = 1'b0;
      run_dp(2, 2, 1'b1, "post_rst");
      consume("post_rst");

      // len = 0 behaves as 1.
      run_dp(0, 1, 1'b0, "len0");
      consume("len0");

      // Random lengths and random consume delays.
      for (int r = 0; r < 8; r++) begin
         int l;
         l = $urandom_range(0, 5);
         run_dp(l, (l == 0) ? 1 : l, 1'b1, "rand");
         held = out;
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            chk("rand hold", 128'(out), 128'(held));
         end
         consume("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
